// File: rtl/pio_fifo.sv
// pio_fifo: TX/RX word FIFO pair between the host bus and one PIO state machine.
// Ports: clk/reset (async, active-high); mach_en qualifies machine strobes;
//   join_tx/join_rx pool storage into one direction; flush clears both FIFOs;
//   TX: tx_wr/tx_wdata (host) -> tx_pull/tx_rdata (machine), tx_empty/full/level;
//   RX: rx_push/rx_wdata (machine) -> rx_rd/rx_rdata (host), rx_empty/full/level;
//   flags [0] tx_overflow [1] rx_overflow [2] rx_underflow, cleared by flag_clr.
module pio_fifo #(
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(2*DEPTH)+1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          mach_en,
    input  logic          join_tx,
    input  logic          join_rx,
    input  logic          flush,
    input  logic          tx_wr,
    input  logic [31:0]   tx_wdata,
    input  logic          tx_pull,
    output logic [31:0]   tx_rdata,
    output logic          tx_empty,
    output logic          tx_full,
    output logic [LW-1:0] tx_level,
    input  logic          rx_push,
    input  logic [31:0]   rx_wdata,
    output logic          rx_full,
    input  logic          rx_rd,
    output logic [31:0]   rx_rdata,
    output logic          rx_empty,
    output logic [LW-1:0] rx_level,
    input  logic [2:0]    flag_clr,
    output logic [2:0]    flags
);

    localparam int NW = 2*DEPTH;
    localparam int AW = $clog2(NW);

    // Shared storage: TX owns the low half, RX the high half, unless joined.
    logic [31:0]   mem_q [NW];

    logic [AW-1:0] tx_rp_q, tx_rp_d, tx_wp_q, tx_wp_d;
    logic [AW-1:0] rx_rp_q, rx_rp_d, rx_wp_q, rx_wp_d;
    logic [LW-1:0] tx_lvl_q, tx_lvl_d, rx_lvl_q, rx_lvl_d;
    logic [1:0]    join_q;
    logic [2:0]    flags_q, flags_d;

    logic          jtx, jrx, clr, tx_on, rx_on;
    logic [LW-1:0] tx_cap, rx_cap;
    logic [AW-1:0] tx_mask, rx_mask, rx_base, rx_ra, rx_wa;
    logic          tx_full_w, tx_empty_w, rx_full_w, rx_empty_w;
    logic          tx_pop, rx_wr, tx_we, tx_re, rx_we, rx_re;
    logic [2:0]    flag_set;

    assign jtx   = join_tx;
    assign jrx   = join_rx & ~join_tx;
    // A join-mode change reshapes the storage, so it behaves like a flush.
    assign clr   = flush | ({join_tx, join_rx} != join_q);
    assign tx_on = ~jrx;
    assign rx_on = ~jtx;

    assign tx_cap  = jtx ? LW'(NW) : LW'(DEPTH);
    assign rx_cap  = jrx ? LW'(NW) : LW'(DEPTH);
    assign tx_mask = jtx ? AW'(NW-1) : AW'(DEPTH-1);
    assign rx_mask = jrx ? AW'(NW-1) : AW'(DEPTH-1);
    assign rx_base = jrx ? '0 : AW'(DEPTH);
    assign rx_ra   = rx_base + rx_rp_q;
    assign rx_wa   = rx_base + rx_wp_q;

    // A direction whose storage is lent away looks both empty and full.
    assign tx_full_w  = ~tx_on | (tx_lvl_q == tx_cap);
    assign tx_empty_w = ~tx_on | (tx_lvl_q == '0);
    assign rx_full_w  = ~rx_on | (rx_lvl_q == rx_cap);
    assign rx_empty_w = ~rx_on | (rx_lvl_q == '0);

    assign tx_pop = tx_pull & mach_en;
    assign rx_wr  = rx_push & mach_en;

    assign tx_we = tx_wr & ~tx_full_w  & ~clr;
    assign tx_re = tx_pop & ~tx_empty_w & ~clr;
    assign rx_we = rx_wr & ~rx_full_w  & ~clr;
    assign rx_re = rx_rd & ~rx_empty_w & ~clr;

    // Writes into a lent-away direction are silently dropped.
    assign flag_set[0] = tx_wr & tx_full_w  & tx_on & ~clr;
    assign flag_set[1] = rx_wr & rx_full_w  & rx_on & ~clr;
    assign flag_set[2] = rx_rd & rx_empty_w & ~clr;

    always_comb begin
        tx_rp_d  = tx_rp_q;
        tx_wp_d  = tx_wp_q;
        rx_rp_d  = rx_rp_q;
        rx_wp_d  = rx_wp_q;
        tx_lvl_d = tx_lvl_q;
        rx_lvl_d = rx_lvl_q;
        if (clr) begin
            tx_rp_d  = '0;
            tx_wp_d  = '0;
            rx_rp_d  = '0;
            rx_wp_d  = '0;
            tx_lvl_d = '0;
            rx_lvl_d = '0;
        end else begin
            if (tx_we) tx_wp_d = (tx_wp_q + AW'(1)) & tx_mask;
            if (tx_re) tx_rp_d = (tx_rp_q + AW'(1)) & tx_mask;
            if (rx_we) rx_wp_d = (rx_wp_q + AW'(1)) & rx_mask;
            if (rx_re) rx_rp_d = (rx_rp_q + AW'(1)) & rx_mask;
            tx_lvl_d = tx_lvl_q + LW'(tx_we) - LW'(tx_re);
            rx_lvl_d = rx_lvl_q + LW'(rx_we) - LW'(rx_re);
        end
        // Set beats clear on the same bit.
        flags_d = (flags_q & ~flag_clr) | flag_set;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_rp_q  <= '0;
            tx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_wp_q  <= '0;
            tx_lvl_q <= '0;
            rx_lvl_q <= '0;
            join_q   <= '0;
            flags_q  <= '0;
        end else begin
            tx_rp_q  <= tx_rp_d;
            tx_wp_q  <= tx_wp_d;
            rx_rp_q  <= rx_rp_d;
            rx_wp_q  <= rx_wp_d;
            tx_lvl_q <= tx_lvl_d;
            rx_lvl_q <= rx_lvl_d;
            join_q   <= {join_tx, join_rx};
            flags_q  <= flags_d;
        end
    end

    // TX and RX regions never overlap, so both writes can land together.
    always_ff @(posedge clk) begin
        if (tx_we) mem_q[tx_wp_q] <= tx_wdata;
        if (rx_we) mem_q[rx_wa]   <= rx_wdata;
    end

    assign tx_rdata = tx_empty_w ? 32'd0 : mem_q[tx_rp_q];
    assign rx_rdata = rx_empty_w ? 32'd0 : mem_q[rx_ra];
    assign tx_empty = tx_empty_w;
    assign tx_full  = tx_full_w;
    assign rx_empty = rx_empty_w;
    assign rx_full  = rx_full_w;
    assign tx_level = tx_on ? tx_lvl_q : '0;
    assign rx_level = rx_on ? rx_lvl_q : '0;
    assign flags    = flags_q;

endmodule

// File: tb/tb_pio_fifo.sv
// tb_pio_fifo: directed and randomized checks of pio_fifo against a
// queue-based reference model of the FIFO pair.
module tb_pio_fifo;

    localparam int DEPTH = 4;
    localparam int LW    = $clog2(2*DEPTH)+1;

    logic          clk = 1'b0;
    logic          reset;
    logic          mach_en, join_tx, join_rx, flush;
    logic          tx_wr, tx_pull, rx_push, rx_rd;
    logic [31:0]   tx_wdata, rx_wdata;
    logic [2:0]    flag_clr;
    logic [31:0]   tx_rdata, rx_rdata;
    logic          tx_empty, tx_full, rx_empty, rx_full;
    logic [LW-1:0] tx_level, rx_level;
    logic [2:0]    flags;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] txq[$];
    logic [31:0] rxq[$];
    logic [2:0]  m_flags;
    logic [1:0]  m_join;

    always #5 clk = ~clk;

    pio_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .mach_en(mach_en),
        .join_tx(join_tx), .join_rx(join_rx), .flush(flush),
        .tx_wr(tx_wr), .tx_wdata(tx_wdata), .tx_pull(tx_pull),
        .tx_rdata(tx_rdata), .tx_empty(tx_empty), .tx_full(tx_full),
        .tx_level(tx_level), .rx_push(rx_push), .rx_wdata(rx_wdata),
        .rx_full(rx_full), .rx_rd(rx_rd), .rx_rdata(rx_rdata),
        .rx_empty(rx_empty), .rx_level(rx_level),
        .flag_clr(flag_clr), .flags(flags)
    );

    function automatic int cap_tx();
        if (join_tx) return 2*DEPTH;
        if (join_rx) return 0;
        return DEPTH;
    endfunction

    function automatic int cap_rx();
        if (join_tx) return 0;
        if (join_rx) return 2*DEPTH;
        return DEPTH;
    endfunction

    // Reference behaviour for one clock edge, from pre-edge state and inputs.
    task automatic model_step();
        int ct, cr, nt, nr;
        logic [2:0] set;
        ct = cap_tx();
        cr = cap_rx();
        set = 3'b000;
        if (flush || ({join_tx, join_rx} != m_join)) begin
            txq.delete();
            rxq.delete();
        end else begin
            nt = txq.size();
            nr = rxq.size();
            if (tx_pull && mach_en && nt > 0) void'(txq.pop_front());
            if (tx_wr) begin
                if (nt == ct) begin
                    if (ct != 0) set[0] = 1'b1;
                end else txq.push_back(tx_wdata);
            end
            if (rx_rd) begin
                if (nr == 0) set[2] = 1'b1;
                else void'(rxq.pop_front());
            end
            if (rx_push && mach_en) begin
                if (nr == cr) begin
                    if (cr != 0) set[1] = 1'b1;
                end else rxq.push_back(rx_wdata);
            end
        end
        m_flags = (m_flags & ~flag_clr) | set;
        m_join  = {join_tx, join_rx};
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mach_en  = 1'b0;
        flush    = 1'b0;
        tx_wr    = 1'b0;
        tx_pull  = 1'b0;
        rx_push  = 1'b0;
        rx_rd    = 1'b0;
        tx_wdata = '0;
        rx_wdata = '0;
        flag_clr = '0;
    endtask

    task automatic clear_flags();
        idle();
        flag_clr = 3'b111;
        cycle();
        idle();
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        join_tx = 1'b0;
        join_rx = 1'b0;
        idle();
        txq.delete();
        rxq.delete();
        m_flags = '0;
        m_join  = '0;
        #3;
        n_cmp++;
        if ({tx_empty, tx_full, rx_empty, rx_full} !== 4'b1010) begin
            n_bad++;
            $display("FAIL reset_status got %b exp 1010",
                     {tx_empty, tx_full, rx_empty, rx_full});
        end
        n_cmp++;
        if ({tx_level, rx_level, flags, tx_rdata, rx_rdata} !== '0) begin
            n_bad++;
            $display("FAIL reset_values lv %0d/%0d fl %b d %h/%h exp 0",
                     tx_level, rx_level, flags, tx_rdata, rx_rdata);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_tx_basic();
        for (int i = 0; i < 4; i++) begin
            idle();
            tx_wr = 1'b1;
            tx_wdata = 32'((i+1) * 'h11);
            cycle();
        end
        idle();
        n_cmp++;
        if (tx_full !== 1'b1 || tx_level !== LW'(4) || flags[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL tx_fill full %b lv %0d fl %b exp 1/4/0",
                     tx_full, tx_level, flags[0]);
        end
        tx_wr = 1'b1;
        tx_wdata = 32'h55;
        cycle();
        idle();
        n_cmp++;
        if (tx_full !== 1'b1 || tx_level !== LW'(4) || flags[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL tx_ovf full %b lv %0d fl %b exp 1/4/1",
                     tx_full, tx_level, flags[0]);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (tx_rdata !== 32'((i+1) * 'h11)) begin
                n_bad++;
                $display("FAIL tx_order[%0d] got %h exp %h",
                         i, tx_rdata, 32'((i+1) * 'h11));
            end
            tx_pull = 1'b1;
            mach_en = 1'b1;
            cycle();
            idle();
        end
        n_cmp++;
        if (tx_empty !== 1'b1 || tx_rdata !== 32'd0) begin
            n_bad++;
            $display("FAIL tx_drain empty %b d %h exp 1/0", tx_empty, tx_rdata);
        end
        clear_flags();
    endtask

    task automatic test_stall();
        tx_wr = 1'b1;
        tx_wdata = 32'hA5;
        cycle();
        idle();
        for (int i = 0; i < 3; i++) begin
            tx_pull = 1'b1;
            mach_en = 1'b0;
            cycle();
            n_cmp++;
            if (tx_rdata !== 32'hA5 || tx_level !== LW'(1)) begin
                n_bad++;
                $display("FAIL stall[%0d] d %h lv %0d exp a5/1",
                         i, tx_rdata, tx_level);
            end
        end
        mach_en = 1'b1;
        cycle();
        idle();
        n_cmp++;
        if (tx_level !== LW'(0) || tx_empty !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_release lv %0d empty %b exp 0/1",
                     tx_level, tx_empty);
        end
    endtask

    task automatic test_simul();
        for (int i = 1; i <= 4; i++) begin
            idle();
            tx_wr = 1'b1;
            tx_wdata = 32'(i);
            cycle();
        end
        tx_wr = 1'b1;
        tx_wdata = 32'h99;
        tx_pull = 1'b1;
        mach_en = 1'b1;
        cycle();
        idle();
        n_cmp++;
        if (tx_level !== LW'(3) || tx_rdata !== 32'd2 || flags[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL full_wr_pop lv %0d d %h fl %b exp 3/2/1",
                     tx_level, tx_rdata, flags[0]);
        end
        for (int i = 2; i <= 4; i++) begin
            n_cmp++;
            if (tx_rdata !== 32'(i)) begin
                n_bad++;
                $display("FAIL no_99[%0d] got %h exp %h", i, tx_rdata, 32'(i));
            end
            tx_pull = 1'b1;
            mach_en = 1'b1;
            cycle();
            idle();
        end
        tx_wr = 1'b1;
        tx_wdata = 32'h77;
        tx_pull = 1'b1;
        mach_en = 1'b1;
        cycle();
        idle();
        n_cmp++;
        if (tx_level !== LW'(1) || tx_rdata !== 32'h77) begin
            n_bad++;
            $display("FAIL empty_wr_pop lv %0d d %h exp 1/77",
                     tx_level, tx_rdata);
        end
        tx_pull = 1'b1;
        mach_en = 1'b1;
        cycle();
        clear_flags();
    endtask

    task automatic test_join_tx();
        tx_wr = 1'b1;
        tx_wdata = 32'hDEAD;
        cycle();
        idle();
        join_tx = 1'b1;
        cycle();
        n_cmp++;
        if (tx_level !== LW'(0) || rx_full !== 1'b1 || rx_empty !== 1'b1 ||
            rx_level !== LW'(0)) begin
            n_bad++;
            $display("FAIL join_flush txlv %0d rxf %b rxe %b rxlv %0d exp 0/1/1/0",
                     tx_level, rx_full, rx_empty, rx_level);
        end
        for (int i = 0; i < 8; i++) begin
            tx_wr = 1'b1;
            tx_wdata = 32'(i);
            cycle();
            n_cmp++;
            if (tx_full !== (i == 7)) begin
                n_bad++;
                $display("FAIL join_full[%0d] got %b exp %b", i, tx_full, i == 7);
            end
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (tx_rdata !== 32'(i)) begin
                n_bad++;
                $display("FAIL join_pop[%0d] got %h exp %h", i, tx_rdata, 32'(i));
            end
            tx_pull = 1'b1;
            mach_en = 1'b1;
            cycle();
            idle();
        end
        for (int i = 8; i < 12; i++) begin
            tx_wr = 1'b1;
            tx_wdata = 32'(i);
            cycle();
        end
        idle();
        for (int i = 4; i < 12; i++) begin
            n_cmp++;
            if (tx_rdata !== 32'(i)) begin
                n_bad++;
                $display("FAIL join_wrap[%0d] got %h exp %h", i, tx_rdata, 32'(i));
            end
            tx_pull = 1'b1;
            mach_en = 1'b1;
            cycle();
            idle();
        end
        join_tx = 1'b0;
        cycle();
    endtask

    task automatic test_rx();
        for (int i = 0; i < 5; i++) begin
            idle();
            rx_push = 1'b1;
            mach_en = 1'b1;
            rx_wdata = 32'h100 + 32'(i);
            cycle();
        end
        idle();
        n_cmp++;
        if (rx_full !== 1'b1 || rx_level !== LW'(4) || flags !== 3'b010) begin
            n_bad++;
            $display("FAIL rx_ovf full %b lv %0d fl %b exp 1/4/010",
                     rx_full, rx_level, flags);
        end
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                n_cmp++;
                if (rx_rdata !== 32'h100 + 32'(i)) begin
                    n_bad++;
                    $display("FAIL rx_order[%0d] got %h exp %h",
                             i, rx_rdata, 32'h100 + 32'(i));
                end
            end
            rx_rd = 1'b1;
            cycle();
            idle();
        end
        n_cmp++;
        if (flags !== 3'b110 || rx_empty !== 1'b1) begin
            n_bad++;
            $display("FAIL rx_unf fl %b empty %b exp 110/1", flags, rx_empty);
        end
        flag_clr = 3'b110;
        cycle();
        idle();
        n_cmp++;
        if (flags !== 3'b000) begin
            n_bad++;
            $display("FAIL flag_clr got %b exp 000", flags);
        end
    endtask

    task automatic test_async_reset();
        rx_rd = 1'b1;
        cycle();
        idle();
        for (int i = 0; i < 2; i++) begin
            tx_wr = 1'b1;
            tx_wdata = $urandom;
            rx_push = 1'b1;
            mach_en = 1'b1;
            rx_wdata = $urandom;
            cycle();
        end
        idle();
        n_cmp++;
        if (tx_level !== LW'(2) || rx_level !== LW'(2) || flags !== 3'b100) begin
            n_bad++;
            $display("FAIL pre_reset lv %0d/%0d fl %b exp 2/2/100",
                     tx_level, rx_level, flags);
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({tx_level, rx_level, flags} !== '0 || tx_empty !== 1'b1 ||
            rx_empty !== 1'b1 || tx_rdata !== 32'd0 || rx_rdata !== 32'd0) begin
            n_bad++;
            $display("FAIL async_reset lv %0d/%0d fl %b e %b/%b exp 0/0/000/1/1",
                     tx_level, rx_level, flags, tx_empty, rx_empty);
        end
        txq.delete();
        rxq.delete();
        m_flags = '0;
        m_join  = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] e_tx, e_rx;
        int ct, cr;
        for (int n = 0; n < 600; n++) begin
            idle();
            mach_en  = ($urandom_range(0, 3) != 0);
            tx_wr    = $urandom_range(0, 1) == 1;
            tx_pull  = $urandom_range(0, 1) == 1;
            rx_push  = $urandom_range(0, 1) == 1;
            rx_rd    = $urandom_range(0, 1) == 1;
            tx_wdata = $urandom;
            rx_wdata = $urandom;
            flush    = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 7) == 0) flag_clr = 3'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                join_tx = $urandom_range(0, 1) == 1;
                join_rx = $urandom_range(0, 1) == 1;
            end
            cycle();
            ct = cap_tx();
            cr = cap_rx();
            e_tx = (txq.size() > 0) ? txq[0] : 32'd0;
            e_rx = (rxq.size() > 0) ? rxq[0] : 32'd0;
            n_cmp++;
            if ({tx_rdata, tx_empty, tx_full, tx_level} !==
                {e_tx, txq.size() == 0, txq.size() == ct, LW'(txq.size())}) begin
                n_bad++;
                $display("FAIL rand_tx[%0d] d %h e %b f %b lv %0d exp %h %b %b %0d",
                         n, tx_rdata, tx_empty, tx_full, tx_level,
                         e_tx, txq.size() == 0, txq.size() == ct, txq.size());
            end
            n_cmp++;
            if ({rx_rdata, rx_empty, rx_full, rx_level, flags} !==
                {e_rx, rxq.size() == 0, rxq.size() == cr, LW'(rxq.size()),
                 m_flags}) begin
                n_bad++;
                $display("FAIL rand_rx[%0d] d %h e %b f %b lv %0d fl %b exp %h %b %b %0d %b",
                         n, rx_rdata, rx_empty, rx_full, rx_level, flags,
                         e_rx, rxq.size() == 0, rxq.size() == cr,
                         rxq.size(), m_flags);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_tx_basic();
        test_stall();
        test_simul();
        test_join_tx();
        test_rx();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
